// File: rtl/trace_pkg.sv
// Shared constants and FSM state encoding for the side-channel trace capture block.
package trace_pkg;
    localparam int DEPTH_DEF = 32;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;
endpackage

// File: rtl/trace_capture_if.sv
// Readout stream: the capture block presents samples, the consumer accepts them.
interface trace_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// Sample store: synchronous write, asynchronous read through a single shared address.
module trace_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/trace_capture.sv
// Captures one trace of leakage samples starting at round 0, then streams it out
// over a valid/ready port; strobes arriving during readout are flagged, not stored.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   trig,
    input  logic                   sample_en,
    input  logic [WIDTH-1:0]       sample_in,
    trace_capture_if.master        rd,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   missed
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);
    localparam cnt_t ONE  = cnt_t'(1);

    state_t           state, state_n;
    cnt_t             rd_idx, rd_idx_n, count_n;
    logic             missed_n, done_n, we, hs, rd_valid_q;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rdata;

    assign hs = rd_valid_q && rd.rd_ready;

    always_comb begin
        state_n  = state;
        count_n  = count;
        rd_idx_n = rd_idx;
        missed_n = missed;
        done_n   = 1'b0;
        we       = 1'b0;
        case (state)
            IDLE: begin
                // A trig coinciding with arm is deliberately not captured.
                if (arm) begin
                    state_n  = ARMED;
                    count_n  = '0;
                    rd_idx_n = '0;
                    missed_n = 1'b0;
                end
            end
            ARMED: begin
                if (trig && sample_en) begin
                    we      = 1'b1;
                    count_n = ONE;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_en) begin
                    we      = 1'b1;
                    count_n = count + ONE;
                    if (count_n == FULL) begin
                        state_n  = READOUT;
                        rd_idx_n = '0;
                    end
                end
            end
            READOUT: begin
                if (sample_en) missed_n = 1'b1;
                if (hs) begin
                    rd_idx_n = rd_idx + ONE;
                    if (rd_idx_n == count) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            rd_idx     <= '0;
            missed     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            rd_idx     <= rd_idx_n;
            missed     <= missed_n;
            done       <= done_n;
            busy       <= (state_n != IDLE);
            rd_valid_q <= (state_n == READOUT);
        end
    end

    // In ARMED count is 0, so the write index is simply count outside READOUT.
    assign addr = (state == READOUT) ? rd_idx[AW-1:0] : count[AW-1:0];

    trace_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (sample_in),
        .rdata (rdata)
    );

    assign rd.rd_data  = rdata;
    assign rd.rd_valid = rd_valid_q;
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 32, number of 8-bit samples captured per trace (power of two, 2..256).
REQ-002 Parameter WIDTH, default 8, sample width; matches the byte-parity leakage vector of the exponentiation core.
REQ-003 clk  input  1  capture clock; the same clock that advances the exponentiation round counter.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 arm  input  1  single-cycle request to arm a new capture.
REQ-006 trig  input  1  high in the cycle in which the exponentiation round counter is at round 0.
REQ-007 sample_en  input  1  strobe; sample_in is valid in this cycle (one strobe per round).
REQ-008 sample_in  input  WIDTH  leakage sample (out_reduced of the exponentiation core).
REQ-009 rd_data  output  WIDTH  sample at the current read index.
REQ-010 rd_valid  output  1  rd_data holds a captured sample.
REQ-011 rd_ready  input  1  consumer accepts rd_data.
REQ-012 busy  output  1  high in the ARMED, CAPTURE and READOUT states.
REQ-013 done  output  1  single-cycle pulse after the last sample is read out.
REQ-014 count  output  $clog2(DEPTH)+1  number of samples stored in the current trace.
REQ-015 missed  output  1  sticky flag: a sample_en arrived while READOUT was active.

Function
REQ-016 The FSM SHALL have the states IDLE, ARMED, CAPTURE and READOUT.
REQ-017 IDLE: arm SHALL move to ARMED on the next edge and clear count and missed.
REQ-018 ARMED: trig&&sample_en SHALL write sample_in to index 0, set count=1 and move to CAPTURE; trig without sample_en or sample_en without trig SHALL be ignored.
REQ-019 CAPTURE: each sample_en SHALL write sample_in to index count and increment count; trig SHALL be ignored.
REQ-020 When the write that makes count==DEPTH completes, the FSM SHALL enter READOUT in the same edge, with the read index at 0.
REQ-021 READOUT: rd_valid SHALL be 1 while read index<count; rd_data SHALL equal the stored sample at the read index and SHALL stay stable while rd_valid&&!rd_ready.
REQ-022 A handshake (rd_valid&&rd_ready) SHALL advance the read index by 1; the final handshake SHALL return the FSM to IDLE with rd_valid=0 and pulse done for exactly one cycle.
REQ-023 sample_en in READOUT SHALL NOT write memory and SHALL set missed; missed SHALL clear only on arm (in IDLE) or rst.
REQ-024 arm outside IDLE SHALL be ignored; arm and trig in the same IDLE cycle SHALL only arm (that trig is not captured).
REQ-025 The index counters SHALL NOT wrap: no write occurs at count==DEPTH, and count saturates at DEPTH.
REQ-026 rd_valid, busy and done SHALL be registered outputs; capture adds no latency (a sample is stored on the edge at which its strobe is sampled).

Reset
REQ-027 rst SHALL force IDLE, count=0, read index=0, rd_valid=0, busy=0, done=0, missed=0; rd_data SHALL be don't-care while rd_valid=0.
REQ-028 rst in the middle of a capture or readout SHALL abandon the trace at the next edge without a done pulse; sample memory contents are not cleared.

Structure
REQ-029 Package trace_pkg SHALL hold the state enumeration and the default DEPTH/WIDTH constants.
REQ-030 The sample storage SHALL be one sub-module, trace_ram (synchronous write, asynchronous read, DEPTH x WIDTH), addressed by the write index in CAPTURE and by the read index in READOUT.

Verification
REQ-031 arm, then trig+sample_en with 0x5A followed by 31 strobes carrying 0x00..0x1E -> count=32, READOUT; with rd_ready=1, rd_data sequence 0x5A,0x00..0x1E, and done pulses once after the 32nd transfer.
REQ-032 Readout with rd_ready low for 3 cycles at index 4 -> rd_data holds sample 4 and rd_valid stays 1; the index advances only after rd_ready rises.
REQ-033 ARMED with sample_en (no trig) for 5 cycles, then trig+sample_en=0xA3 -> count=1 and stored[0]=0xA3.
REQ-034 sample_en pulses during READOUT -> missed=1 and the memory is unchanged; missed stays 1 until the next arm.
REQ-035 rst asserted after 10 captured samples -> next cycle IDLE, busy=0, count=0, no done pulse; a re-arm then captures normally.
REQ-036 arm pulsed in CAPTURE and READOUT -> no state change and count unaffected.
